// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, Nk/Nr lookups and GF(2^8) helpers
// used by the key schedule and the S-box unit.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128  = 2'b00,
        KL_192  = 2'b01,
        KL_256  = 2'b10,
        KL_RSVD = 2'b11
    } key_len_t;

    localparam int MAX_WORDS = 60;

    function automatic logic [3:0] nk_of(key_len_t kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_t kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_fwd(logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(logic [7:0] x);
        logic [7:0] b;
        b = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/sub_bytes.sv
// Byte-wise AES S-box over a WIDTH-bit word, PAR bytes per cycle.
// start_i latches data_i; done_o pulses for one cycle once data_o holds the result.
module sub_bytes
    import aes_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PAR   = 4,
    parameter int OP    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int NB  = WIDTH / 8;
    localparam int NCH = NB / PAR;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (start_i) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end else if (r_busy) begin
                if (r_cnt == CW'(NCH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // One chunk of PAR bytes is substituted in place per busy cycle.
    always_ff @(posedge clk) begin
        if (start_i) begin
            r_data <= data_i;
        end else if (r_busy) begin
            for (int p = 0; p < PAR; p++) begin
                if (OP == 1)
                    r_data[(int'(r_cnt) * PAR + p) * 8 +: 8] <= sbox_fwd(r_data[(int'(r_cnt) * PAR + p) * 8 +: 8]);
                else
                    r_data[(int'(r_cnt) * PAR + p) * 8 +: 8] <= sbox_inv(r_data[(int'(r_cnt) * PAR + p) * 8 +: 8]);
            end
        end
    end

    assign done_o = r_done;
    assign data_o = r_data;

endmodule

// File: rtl/key_expand_engine.sv
// AES-128/192/256 key schedule: one word per step into a 60x32 word store,
// with a registered round-key read port usable while expansion is running.
module key_expand_engine
    import aes_pkg::*;
#(
    parameter int SBOX_PAR = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] key_i,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         rk_valid_o,
    output logic         busy_o,
    output logic         ready_o,
    output logic         err_o
);

    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, SUB_WAIT, READY} state_t;

    state_t       r_state, w_state_nxt;
    key_len_t     r_len;
    logic [255:0] r_key;
    logic [31:0]  r_w [MAX_WORDS];
    logic [5:0]   r_i;
    logic [2:0]   r_imod;
    logic [7:0]   r_rcon;
    logic         r_rot;
    logic         r_err;
    logic [127:0] r_rk;
    logic         r_rk_vld;

    logic [3:0]   w_nk, w_nr;
    logic [5:0]   w_nk6, w_total;
    logic         w_start_ok, w_start_go, w_start_bad;
    logic [31:0]  w_prev, w_back, w_rotword;
    logic         w_load, w_we, w_sb_start, w_rot, w_rcon_adv;
    logic [31:0]  w_wdata, w_sb_in, w_sb_out;
    logic         w_sb_done, w_rd_ok;

    assign w_nk      = nk_of(r_len);
    assign w_nr      = nr_of(r_len);
    assign w_nk6     = {2'b00, w_nk};
    assign w_total   = {w_nr + 4'd1, 2'b00};
    assign w_prev    = r_w[r_i - 6'd1];
    assign w_back    = r_w[r_i - w_nk6];
    assign w_rotword = {w_prev[23:0], w_prev[31:24]};

    assign w_start_ok  = start_i && (r_state == IDLE || r_state == READY);
    assign w_start_go  = w_start_ok && (key_len_i != KL_RSVD);
    assign w_start_bad = w_start_ok && (key_len_i == KL_RSVD);

    sub_bytes #(
        .WIDTH (32),
        .PAR   (SBOX_PAR),
        .OP    (1)
    ) u_sub_bytes (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (w_sb_start),
        .data_i  (w_sb_in),
        .done_o  (w_sb_done),
        .data_o  (w_sb_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_we        = 1'b0;
        w_wdata     = w_prev ^ w_back;
        w_sb_start  = 1'b0;
        w_sb_in     = w_rotword;
        w_rot       = 1'b0;
        w_rcon_adv  = 1'b0;
        case (r_state)
            IDLE, READY: begin
                if (w_start_go) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = EXPAND;
            end
            EXPAND: begin
                if (r_i == w_total) begin
                    w_state_nxt = READY;
                end else if (r_imod == 3'd0) begin
                    w_sb_start  = 1'b1;
                    w_rot       = 1'b1;
                    w_state_nxt = SUB_WAIT;
                end else if (w_nk == 4'd8 && r_imod == 3'd4) begin
                    w_sb_start  = 1'b1;
                    w_sb_in     = w_prev;
                    w_state_nxt = SUB_WAIT;
                end else begin
                    w_we = 1'b1;
                end
            end
            SUB_WAIT: begin
                // done only matters here; a stray pulse in any other state is dropped
                if (w_sb_done) begin
                    w_we        = 1'b1;
                    w_wdata     = w_sb_out ^ w_back ^ (r_rot ? {r_rcon, 24'h0} : 32'h0);
                    w_rcon_adv  = r_rot;
                    w_state_nxt = EXPAND;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rd_ok = (rk_idx_i <= w_nr) && ({rk_idx_i, 2'b11} < r_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len    <= KL_128;
            r_i      <= '0;
            r_imod   <= '0;
            r_rcon   <= 8'h01;
            r_rot    <= 1'b0;
            r_err    <= 1'b0;
            r_rk     <= '0;
            r_rk_vld <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_go) begin
                r_len <= key_len_t'(key_len_i);
                r_i   <= '0;
            end
            if (w_load) begin
                r_i    <= w_nk6;
                r_imod <= '0;
                r_rcon <= 8'h01;
            end
            if (w_we) begin
                r_i    <= r_i + 6'd1;
                r_imod <= (r_imod == 3'(w_nk - 4'd1)) ? 3'd0 : r_imod + 3'd1;
            end
            if (w_sb_start) r_rot  <= w_rot;
            if (w_rcon_adv) r_rcon <= xtime(r_rcon);
            r_rk_vld <= w_rd_ok;
            r_rk     <= w_rd_ok ? {r_w[{rk_idx_i, 2'b00}], r_w[{rk_idx_i, 2'b01}],
                                   r_w[{rk_idx_i, 2'b10}], r_w[{rk_idx_i, 2'b11}]} : 128'h0;
        end
    end

    // Word store and key latch carry no reset; validity is governed by r_i alone.
    always_ff @(posedge clk) begin
        if (w_start_go) r_key <= key_i;
        if (w_load) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(w_nk)) r_w[k] <= r_key[255 - 32 * k -: 32];
            end
        end
        if (w_we) r_w[r_i] <= w_wdata;
    end

    assign rk_o       = r_rk;
    assign rk_valid_o = r_rk_vld;
    assign busy_o     = (r_state == LOAD) || (r_state == EXPAND) || (r_state == SUB_WAIT);
    assign ready_o    = (r_state == READY);
    assign err_o      = r_err;

endmodule

// File: tb/tb_key_expand_engine.sv
// Scoreboard bench for key_expand_engine using the FIPS-197 key-expansion vectors.
module tb_key_expand_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [1:0]   key_len_i;
    logic [255:0] key_i;
    logic [3:0]   rk_idx_i;
    logic [127:0] rk_o;
    logic         rk_valid_o;
    logic         busy_o;
    logic         ready_o;
    logic         err_o;

    key_expand_engine #(.SBOX_PAR(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .key_len_i  (key_len_i),
        .key_i      (key_i),
        .rk_idx_i   (rk_idx_i),
        .rk_o       (rk_o),
        .rk_valid_o (rk_valid_o),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        string        tag;
        logic         vld;
        logic [127:0] rk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    // Drive an index, push the expected result, pop and compare once the DUT registers it.
    task automatic rd(input string tag, input logic [3:0] idx, input logic vld, input logic [127:0] rk);
        exp_t e;
        @(negedge clk);
        rk_idx_i = idx;
        e.tag = tag; e.vld = vld; e.rk = rk;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(e.tag, {rk_valid_o, rk_o}, {e.vld, e.rk});
    endtask

    task automatic start_key(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        start_i   = 1'b1;
        key_len_i = len;
        key_i     = key;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_o && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, ready_o, 1'b1);
        chk({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start_i   = 1'b0;
        key_len_i = 2'b00;
        key_i     = '0;
        rk_idx_i  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {busy_o, ready_o, err_o, rk_valid_o, rk_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst_idx0", 4'd0, 1'b0, 128'h0);

        // AES-128 while polling round key 1
        @(negedge clk);
        rk_idx_i = 4'd1;
        start_key(2'b00, {K128, 128'h0});
        chk("poll_pre", rk_valid_o, 1'b0);
        begin
            int n = 0;
            while (!rk_valid_o && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("poll_rise", rk_valid_o, 1'b1);
        chk("poll_busy", busy_o, 1'b1);
        chk("poll_rk", rk_o, 128'ha0fafe1788542cb123a339392a6c7605);
        wait_ready("a128_ready");
        rd("a128_idx0", 4'd0, 1'b1, K128);
        rd("a128_idx10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd("a128_idx11", 4'd11, 1'b0, 128'h0);
        rd("a128_idx15", 4'd15, 1'b0, 128'h0);

        // reserved length in READY
        @(negedge clk);
        start_i   = 1'b1;
        key_len_i = 2'b11;
        key_i     = '1;
        @(posedge clk);
        #1;
        chk("rsvd_err", {err_o, ready_o, busy_o}, 3'b110);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rsvd_err_clr", {err_o, ready_o}, 2'b01);
        rd("rsvd_idx10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192 with a second start during expansion
        start_key(2'b01, {K192, 64'h0});
        chk("a192_busy", {busy_o, ready_o}, 2'b10);
        repeat (2) @(negedge clk);
        start_i   = 1'b1;
        key_len_i = 2'b10;
        key_i     = K256;
        @(negedge clk);
        start_i   = 1'b0;
        key_len_i = 2'b11;
        @(negedge clk);
        chk("mid_start_noerr", err_o, 1'b0);
        wait_ready("a192_ready");
        rd("a192_idx0", 4'd0, 1'b1, K192[191:64]);
        rd("a192_idx1", 4'd1, 1'b1, {K192[63:0], 64'hfe0c91f72402f5a5});
        rd("a192_idx12", 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
        rd("a192_idx13", 4'd13, 1'b0, 128'h0);

        // AES-256
        start_key(2'b10, K256);
        wait_ready("a256_ready");
        rd("a256_idx0", 4'd0, 1'b1, K256[255:128]);
        rd("a256_idx1", 4'd1, 1'b1, K256[127:0]);
        rd("a256_idx14", 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
        rd("a256_idx15", 4'd15, 1'b0, 128'h0);

        // reset while waiting on the S-box
        rk_idx_i = 4'd0;
        start_key(2'b00, {K128, 128'h0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_outs", {busy_o, ready_o, rk_valid_o}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        rd("midrst_idx0", 4'd0, 1'b0, 128'h0);
        rd("midrst_idx10", 4'd10, 1'b0, 128'h0);
        start_key(2'b00, {K128, 128'h0});
        wait_ready("re128_ready");
        rd("re128_idx1", 4'd1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd("re128_idx10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
